// File: rtl/mem_bridge_pkg.sv
// Shared types and constants for the CPU-to-RAM bridge.
package mem_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RMW_WAIT,
        WR,
        DONE
    } state_t;

    localparam logic [3:0] SEL_FULL = 4'b1111;
    localparam logic [3:0] SEL_NONE = 4'b0000;

endpackage

// File: rtl/mem_byte_merge.sv
// Per-lane byte merge for partial-word stores: lane i comes from new_word when sel[i].
module mem_byte_merge
    import mem_bridge_pkg::*;
(
    input  logic [31:0] old_word_i,
    input  logic [31:0] new_word_i,
    input  logic [3:0]  sel_i,
    output logic [31:0] merged_o
);

    for (genvar i = 0; i < 4; i++) begin : g_lane
        assign merged_o[8*i +: 8] = sel_i[i] ? new_word_i[8*i +: 8] : old_word_i[8*i +: 8];
    end

endmodule

// File: rtl/mem_bridge.sv
// Adapts the byte-addressed CPU memory port to a word-addressed RAM with a
// 1-cycle registered read; partial stores are done as read-modify-write.
module mem_bridge
    import mem_bridge_pkg::*;
#(
    parameter int DEPTH  = 4096,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [31:0]       adr_to_mem,
    input  logic [31:0]       data_to_mem,
    input  logic [3:0]        sel_to_mem,
    output logic [31:0]       data_from_mem,
    output logic              mem_busy,
    output logic [ADDR_W-1:0] ram_adr,
    output logic              ram_read_en,
    output logic              ram_write_en,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    state_t            state_q;
    logic [ADDR_W-1:0] idx_q;
    logic [31:0]       data_q;
    logic [3:0]        sel_q;
    logic [31:0]       wdata_q;
    logic [31:0]       dout_q;

    logic              idle;
    logic              req;
    logic              in_range;
    logic              sel_full;
    logic              sel_none;
    logic [ADDR_W-1:0] in_idx;
    logic [31:0]       merged;
    logic              unused_adr_lo;

    assign unused_adr_lo = ^adr_to_mem[1:0];

    assign idle     = (state_q == IDLE);
    assign req      = mem_read | mem_write;
    assign in_idx   = adr_to_mem[ADDR_W+1:2];
    assign in_range = ({2'b00, adr_to_mem[31:2]} < DEPTH_W);
    assign sel_full = (sel_to_mem == SEL_FULL);
    assign sel_none = (sel_to_mem == SEL_NONE);

    mem_byte_merge u_merge (
        .old_word_i (ram_rdata),
        .new_word_i (data_q),
        .sel_i      (sel_q),
        .merged_o   (merged)
    );

    // The read strobe must fire in the accept cycle so the RAM's registered
    // read lands in RD_WAIT/RMW_WAIT; hence strobes are decoded, not registered.
    assign ram_read_en  = !rst && idle && in_range &&
                          (mem_write ? (!sel_full && !sel_none) : mem_read);
    assign ram_write_en = !rst && (state_q == WR);
    assign ram_adr      = rst ? '0 : ((idle && req) ? in_idx : idx_q);
    assign ram_wdata    = wdata_q;
    assign data_from_mem = dout_q;
    assign mem_busy     = !rst && ((state_q != IDLE && state_q != DONE) || (idle && req));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            data_q  <= '0;
            sel_q   <= '0;
            wdata_q <= '0;
            dout_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // Write takes priority; a simultaneous read is dropped.
                    if (mem_write) begin
                        idx_q  <= in_idx;
                        data_q <= data_to_mem;
                        sel_q  <= sel_to_mem;
                        if (!in_range || sel_none) begin
                            state_q <= DONE;
                        end else if (sel_full) begin
                            wdata_q <= data_to_mem;
                            state_q <= WR;
                        end else begin
                            state_q <= RMW_WAIT;
                        end
                    end else if (mem_read) begin
                        idx_q <= in_idx;
                        if (!in_range) begin
                            dout_q  <= '0;
                            state_q <= DONE;
                        end else begin
                            state_q <= RD_WAIT;
                        end
                    end
                end
                RD_WAIT: begin
                    dout_q  <= ram_rdata;
                    state_q <= DONE;
                end
                RMW_WAIT: begin
                    wdata_q <= merged;
                    state_q <= WR;
                end
                WR:      state_q <= DONE;
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bridge.sv
// Randomized scoreboard bench for mem_bridge with a word-array reference model.
module tb_mem_bridge;

    localparam int DEPTH  = 4096;
    localparam int ADDR_W = 12;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              mem_read, mem_write;
    logic [31:0]       adr_to_mem, data_to_mem;
    logic [3:0]        sel_to_mem;
    logic [31:0]       data_from_mem;
    logic              mem_busy;
    logic [ADDR_W-1:0] ram_adr;
    logic              ram_read_en, ram_write_en;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    mem_bridge #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .adr_to_mem    (adr_to_mem),
        .data_to_mem   (data_to_mem),
        .sel_to_mem    (sel_to_mem),
        .data_from_mem (data_from_mem),
        .mem_busy      (mem_busy),
        .ram_adr       (ram_adr),
        .ram_read_en   (ram_read_en),
        .ram_write_en  (ram_write_en),
        .ram_wdata     (ram_wdata),
        .ram_rdata     (ram_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] seed(int i);
        return (32'(i) * 32'h9E3779B9) ^ 32'hA5C30F1E;
    endfunction

    // RAM model: full-word writes, read data registered one cycle after strobe.
    logic [31:0] ram [DEPTH];
    bit init_done = 1'b0;
    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= seed(i);
            init_done <= 1'b1;
        end else begin
            if (ram_write_en) ram[ram_adr] <= ram_wdata;
            if (ram_read_en) ram_rdata <= ram[ram_adr];
        end
    end

    // Reference model state.
    logic [31:0] mem_ref [DEPTH];
    logic [31:0] dout_ref;

    typedef struct {
        int          start;
        bit          chk_lat;
        int          lat;
        logic [31:0] dout;
        int          nrd;
        int          nwr;
        logic [11:0] idx;
        logic [31:0] word;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   passed = 0;
    bit   directed = 1'b0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: counts strobes per transaction and compares when busy drops.
    int m_rd = 0;
    int m_wr = 0;
    always @(negedge clk) begin
        if (!rst && init_done) begin
            if (ram_read_en || ram_write_en)
                check("rd_wr_overlap", 32'(ram_read_en & ram_write_en), 32'd0);
            if (q.size() == 0) begin
                if (!directed && (ram_read_en || ram_write_en))
                    check("stray_strobe", 32'({ram_read_en, ram_write_en}), 32'd0);
            end else begin
                if (ram_read_en) begin
                    m_rd++;
                    check("rd_adr", 32'(ram_adr), 32'(q[0].idx));
                end
                if (ram_write_en) begin
                    m_wr++;
                    check("wr_adr", 32'(ram_adr), 32'(q[0].idx));
                    check("wr_data", ram_wdata, q[0].word);
                end
                if (!mem_busy) begin
                    if (q[0].chk_lat) check("latency", 32'(cyc - q[0].start), 32'(q[0].lat));
                    check("dout", data_from_mem, q[0].dout);
                    check("n_rd", 32'(m_rd), 32'(q[0].nrd));
                    check("n_wr", 32'(m_wr), 32'(q[0].nwr));
                    void'(q.pop_front());
                    m_rd = 0;
                    m_wr = 0;
                end
            end
        end
    end

    task automatic finish_now();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    endtask

    // Issues one request (caller is just past a posedge), pushes the model's
    // expectation, holds inputs until busy low, then releases after DONE.
    task automatic do_req(bit rd, bit wr, logic [31:0] adr, logic [31:0] data, logic [3:0] sel);
        exp_t        e;
        bit          oor;
        logic [11:0] idx;
        logic [31:0] nw;
        int          n;
        mem_read    = rd;
        mem_write   = wr;
        adr_to_mem  = adr;
        data_to_mem = data;
        sel_to_mem  = sel;
        oor = (adr[31:2] >= 30'(DEPTH));
        idx = adr[13:2];
        e.start = cyc; e.chk_lat = !oor; e.lat = 1;
        e.nrd = 0; e.nwr = 0; e.idx = idx; e.word = '0;
        if (wr) begin
            if (!oor && sel != 4'h0) begin
                nw = mem_ref[idx];
                for (int b = 0; b < 4; b++) if (sel[b]) nw[8*b +: 8] = data[8*b +: 8];
                e.word = nw;
                e.nwr  = 1;
                e.nrd  = (sel == 4'hF) ? 0 : 1;
                e.lat  = (sel == 4'hF) ? 2 : 3;
                mem_ref[idx] = nw;
            end
        end else if (!oor) begin
            e.nrd = 1;
            e.lat = 2;
            dout_ref = mem_ref[idx];
        end else begin
            dout_ref = '0;
        end
        e.dout = dout_ref;
        q.push_back(e);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (mem_busy && n < 20);
        if (mem_busy) begin
            checks++;
            $display("FAIL busy_timeout: busy still %b after %0d cycles, required 0", mem_busy, n);
            finish_now();
        end
        @(posedge clk); #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    initial begin
        logic [31:0] a, d;
        logic [3:0]  s;
        bit          rd, wr, wr_seen;
        int          r, n;

        mem_read = 1'b1; mem_write = 1'b0;
        adr_to_mem = 32'h10; data_to_mem = '0; sel_to_mem = '0;
        for (int i = 0; i < DEPTH; i++) mem_ref[i] = seed(i);
        dout_ref = '0;

        repeat (2) @(negedge clk);
        check("rst_busy",  32'(mem_busy), 32'd0);
        check("rst_rd_en", 32'(ram_read_en), 32'd0);
        check("rst_wr_en", 32'(ram_write_en), 32'd0);
        check("rst_adr",   32'(ram_adr), 32'd0);
        check("rst_wdata", ram_wdata, 32'd0);
        check("rst_dout",  data_from_mem, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; mem_read = 1'b0;
        @(posedge clk); #1;

        do_req(0, 1, 32'h10, 32'hDEADBEEF, 4'hF);
        do_req(1, 0, 32'h10, 32'h0, 4'h0);
        do_req(0, 1, 32'h10, 32'h0000AA00, 4'b0010);
        do_req(1, 0, 32'h10, 32'h0, 4'h0);
        check("rmw_word4", mem_ref[4], 32'hDEADAAEF);
        do_req(0, 1, 32'h20, 32'h12345678, 4'hF);
        do_req(0, 1, 32'h20, 32'hFFFFFFFF, 4'h0);
        do_req(1, 0, 32'h20, 32'h0, 4'h0);
        do_req(1, 1, 32'h8, 32'h55, 4'hF);
        do_req(1, 0, 32'h8, 32'h0, 4'h0);
        do_req(1, 0, 32'h4000, 32'h0, 4'h0);
        do_req(0, 1, 32'h4000, 32'hCAFEF00D, 4'hF);
        do_req(0, 1, 32'h4004, 32'hCAFEF00D, 4'b0101);

        for (int t = 0; t < 300; t++) begin
            r  = $urandom_range(0, 9);
            rd = (r < 5) || (r == 9);
            wr = (r >= 5);
            if ($urandom_range(0, 9) == 0) begin
                a = $urandom();
                if (a[31:14] == 18'd0) a[20] = 1'b1;
            end else begin
                a = 32'($urandom_range(0, 15)) * 32'd4 + 32'($urandom_range(0, 3));
            end
            d = $urandom();
            r = $urandom_range(0, 5);
            s = (r == 0) ? 4'h0 : (r == 1) ? 4'hF : 4'($urandom_range(0, 15));
            do_req(rd, wr, a, d, s);
            n = $urandom_range(0, 2);
            repeat (n) begin @(posedge clk); #1; end
        end

        // Reset while the RMW read is outstanding: the write must never happen.
        directed = 1'b1;
        @(posedge clk); #1;
        mem_write = 1'b1; adr_to_mem = 32'h14; data_to_mem = 32'h00770000; sel_to_mem = 4'b0100;
        @(posedge clk); #1;
        check("rmw_busy", 32'(mem_busy), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_busy",  32'(mem_busy), 32'd0);
        check("mid_rst_wr_en", 32'(ram_write_en), 32'd0);
        check("mid_rst_rd_en", 32'(ram_read_en), 32'd0);
        check("mid_rst_adr",   32'(ram_adr), 32'd0);
        check("mid_rst_wdata", ram_wdata, 32'd0);
        check("mid_rst_dout",  data_from_mem, 32'd0);
        mem_write = 1'b0;
        dout_ref = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        wr_seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            wr_seen |= ram_write_en;
        end
        check("no_wr_after_rst", 32'(wr_seen), 32'd0);
        check("rmw_word_kept", ram[5], mem_ref[5]);
        directed = 1'b0;
        @(posedge clk); #1;
        do_req(1, 0, 32'h14, 32'h0, 4'h0);

        n = 0;
        while (q.size() != 0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            $display("FAIL drain: %0d transactions left, required 0", q.size());
        end
        finish_now();
    end

endmodule
